// File: rtl/conv_complex_reader.sv
// Streams a captured complex convolution result one sample per handshake; 1-cycle capture-to-valid latency.
// Holds the current sample under m_ready=0; optional magnitude output via CONV_COMPLEX_READER_MAG_EN.
module conv_complex_reader #(
    parameter int QI          = 3,
    parameter int QF          = 3,
    parameter int NUM_ELEMS   = 100,
    parameter int WORD_LENGTH = QI + QF
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          conv_valid,
    input  logic [2*WORD_LENGTH*(NUM_ELEMS+2)-1:0]        conv_data,
    input  logic                                          conv_overflow,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic signed [WORD_LENGTH-1:0]                 m_re,
    output logic signed [WORD_LENGTH-1:0]                 m_im,
    output logic [$clog2(NUM_ELEMS+2)-1:0]                m_index,
    output logic                                          m_last,
    output logic                                          busy,
    output logic                                          overflow,
    output logic                                          drop,
    output logic                                          done
`ifdef CONV_COMPLEX_READER_MAG_EN
    ,
    output logic [2*WORD_LENGTH:0]                        m_mag
`endif
);

    localparam int NUM_OUT = NUM_ELEMS + 2;
    localparam int IW      = $clog2(NUM_OUT);
    localparam int WL      = WORD_LENGTH;
    localparam int SW      = 2 * WORD_LENGTH;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [SW*NUM_OUT-1:0]  r_buf;
    logic                   r_valid;
    logic signed [WL-1:0]   r_re;
    logic signed [WL-1:0]   r_im;
    logic [IW-1:0]          r_idx;
    logic                   r_ovf;
    logic                   r_drop;
    logic                   r_done;

    logic [SW*NUM_OUT-1:0]  w_buf_nxt;
    logic                   w_valid_nxt;
    logic signed [WL-1:0]   w_re_nxt;
    logic signed [WL-1:0]   w_im_nxt;
    logic [IW-1:0]          w_idx_nxt;
    logic                   w_ovf_nxt;
    logic                   w_drop_nxt;
    logic                   w_done_nxt;
    logic                   w_load;
    logic [SW-1:0]          w_word;
    logic [IW-1:0]          w_idx_inc;
    logic                   w_xfer;
    logic                   w_at_last;

    assign w_xfer    = r_valid && m_ready;
    assign w_at_last = (r_idx == IW'(NUM_OUT - 1));
    assign w_idx_inc = r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_ovf_nxt   = r_ovf;
        w_drop_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_word      = '0;
        w_re_nxt    = r_re;
        w_im_nxt    = r_im;

        case (r_state)
            IDLE: begin
                if (conv_valid) begin
                    if (conv_overflow) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        // Sample 0 comes straight from the input so it is valid one cycle after capture.
                        w_buf_nxt   = conv_data;
                        w_ovf_nxt   = 1'b0;
                        w_valid_nxt = 1'b1;
                        w_idx_nxt   = '0;
                        w_word      = conv_data[SW-1:0];
                        w_load      = 1'b1;
                        w_state_nxt = STREAM;
                    end
                end
            end
            STREAM: begin
                // Any request while streaming, including on the final transfer, is discarded.
                if (conv_valid) begin
                    w_drop_nxt = 1'b1;
                end
                if (w_xfer) begin
                    if (w_at_last) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_word    = r_buf[SW*int'(w_idx_inc) +: SW];
                        w_load    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_re_nxt = w_word[SW-1:WL];
            w_im_nxt = w_word[WL-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_valid <= 1'b0;
            r_re    <= '0;
            r_im    <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_valid <= w_valid_nxt;
            r_re    <= w_re_nxt;
            r_im    <= w_im_nxt;
            r_idx   <= w_idx_nxt;
            r_ovf   <= w_ovf_nxt;
            r_drop  <= w_drop_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef CONV_COMPLEX_READER_MAG_EN
    logic signed [SW:0] w_re_x;
    logic signed [SW:0] w_im_x;
    logic [SW:0]        w_mag_nxt;
    logic [SW:0]        r_mag;

    // Squares of sign-extended words; the sum of two squares always fits in SW+1 bits.
    always_comb begin
        w_re_x    = {{(WL+1){w_re_nxt[WL-1]}}, w_re_nxt};
        w_im_x    = {{(WL+1){w_im_nxt[WL-1]}}, w_im_nxt};
        w_mag_nxt = $unsigned(w_re_x * w_re_x + w_im_x * w_im_x);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag <= '0;
        end else begin
            r_mag <= w_mag_nxt;
        end
    end

    assign m_mag = r_mag;
`endif

    assign m_valid  = r_valid;
    assign m_re     = r_re;
    assign m_im     = r_im;
    assign m_index  = r_idx;
    assign m_last   = r_valid && w_at_last;
    assign busy     = (r_state == STREAM);
    assign overflow = r_ovf;
    assign drop     = r_drop;
    assign done     = r_done;

endmodule
